// File: rtl/btn_pkg.sv
// Shared types and constants for the button debouncer: FSM state encoding,
// synchronizer depth and the counter-width helper.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam int SYNC_STAGES = 2;

   // Width able to hold the larger of the two interval lengths without wrapping.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Flop synchronizer for an asynchronous pin; resets to a selectable idle level
// so the downstream logic sees "released" right after reset.
module sync_2ff
   import btn_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a bouncing button into a registered level plus press/release strobes.
// Define BTN_DEBOUNCE_LONG_PRESS_EN to add a one-shot long-press strobe.
module button_debouncer
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int LONG_CYCLES     = 6000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic          w_sync;
   logic          w_pressed;
   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_db_cnt;
   logic [CW-1:0] w_db_cnt_nxt;
   logic          r_level;
   logic          w_level_nxt;
   logic          r_press;
   logic          w_press_nxt;
   logic          r_release;
   logic          w_release_nxt;

   sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (btn_in),
      .o_q   (w_sync)
   );

   assign w_pressed = w_sync ^ ACTIVE_LOW;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_db_cnt  <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_db_cnt  <= w_db_cnt_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   // Counter defaults to zero, so it only survives while a wait state persists;
   // any bounce back out of a wait state restarts the full interval.
   always_comb begin
      w_next        = r_state;
      w_db_cnt_nxt  = '0;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pressed) w_next = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!w_pressed) begin
               w_next = IDLE;
            end else if (r_db_cnt >= DB_LAST) begin
               w_next      = HELD;
               w_level_nxt = 1'b1;
               w_press_nxt = 1'b1;
            end else begin
               w_db_cnt_nxt = sat_inc(r_db_cnt);
            end
         end
         HELD: begin
            if (!w_pressed) w_next = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (w_pressed) begin
               w_next = HELD;
            end else if (r_db_cnt >= DB_LAST) begin
               w_next        = IDLE;
               w_level_nxt   = 1'b0;
               w_release_nxt = 1'b1;
            end else begin
               w_db_cnt_nxt = sat_inc(r_db_cnt);
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign btn_level     = r_level;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

   logic [CW-1:0] r_long_cnt;
   logic          r_long;

   // Counts from the level rise; saturation past LONG_LAST keeps it one-shot per press.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_long_cnt <= '0;
         r_long     <= 1'b0;
      end else begin
         r_long <= 1'b0;
         if (r_state == HELD || r_state == RELEASE_WAIT) begin
            if (r_long_cnt == LONG_LAST) r_long <= 1'b1;
            r_long_cnt <= sat_inc(r_long_cnt);
         end else begin
            r_long_cnt <= '0;
         end
      end
   end

   assign long_pulse = r_long;
`else
   assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized scoreboard bench for button_debouncer with a window-based
// reference model plus directed edge-timing checks.
module tb_button_debouncer;

   localparam int D = 4;
   localparam int L = 10;

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic long_pulse;

   always #5 clk = ~clk;

   button_debouncer #(
      .DEBOUNCE_CYCLES (D),
      .ACTIVE_LOW      (1'b1),
      .LONG_CYCLES     (L)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse)
   );

   typedef struct packed {
      logic level;
      logic press;
      logic rel;
      logic lng;
   } out_t;

   typedef struct {
      int   edge_n;
      out_t o;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passed = 0;
   int   edge_n = 0;

   // Reference model: an accepted level change happens once the value seen
   // after the synchronizer has disagreed with the level for D+1 edges in a row.
   bit   m_level;
   bit   m_smp[$];
   bit   m_seen_q[$];
   int   m_rise_edge;
   bit   m_rise_valid;

   int   press_edges[$];
   int   rel_edges[$];
   int   long_edges[$];

   function automatic out_t model_edge(input bit b, input bit r);
      out_t o;
      bit   seen;
      bit   all_diff;
      o = '0;
      if (r) begin
         m_level      = 1'b0;
         m_smp.delete();
         m_seen_q.delete();
         m_rise_valid = 1'b0;
         return o;
      end
      m_smp.push_back(b == 1'b0);
      seen = (m_smp.size() >= 3) ? m_smp[m_smp.size() - 3] : 1'b0;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      if (m_level && m_rise_valid && (edge_n - m_rise_edge == L)) o.lng = 1'b1;
`endif
      m_seen_q.push_back(seen);
      if (m_seen_q.size() > D + 1) void'(m_seen_q.pop_front());
      all_diff = 1'b1;
      foreach (m_seen_q[i]) if (m_seen_q[i] == m_level) all_diff = 1'b0;
      if (m_seen_q.size() == D + 1 && all_diff) begin
         m_level = ~m_level;
         m_seen_q.delete();
         if (m_level) begin
            o.press      = 1'b1;
            m_rise_edge  = edge_n;
            m_rise_valid = 1'b1;
         end else begin
            o.rel        = 1'b1;
            m_rise_valid = 1'b0;
         end
      end
      o.level = m_level;
      return o;
   endfunction

   task automatic step(input bit b, input bit r);
      exp_t e;
      @(negedge clk);
      btn_in = b;
      rst    = r;
      edge_n++;
      e.edge_n = edge_n;
      e.o      = model_edge(b, r);
      sb_q.push_back(e);
   endtask

   task automatic hold(input bit b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got == req) passed++;
      else $display("FAIL %s: got %0d required %0d", name, got, req);
   endtask

   task automatic clear_obs();
      press_edges.delete();
      rel_edges.delete();
      long_edges.delete();
   endtask

   // Monitor: every clock edge that has a scoreboard entry is compared.
   exp_t mon_e;
   out_t mon_a;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            mon_a = {btn_level, press_pulse, release_pulse, long_pulse};
            checks++;
            if (mon_a === mon_e.o) passed++;
            else $display("FAIL outputs edge=%0d level/press/release/long got=%b required=%b",
                          mon_e.edge_n, mon_a, mon_e.o);
            if (press_pulse === 1'b1)   press_edges.push_back(mon_e.edge_n);
            if (release_pulse === 1'b1) rel_edges.push_back(mon_e.edge_n);
            if (long_pulse === 1'b1)    long_edges.push_back(mon_e.edge_n);
         end
      end
   end

   initial begin
      int e0;
      int r0;
      int len;
      bit b;
      rst    = 1'b1;
      btn_in = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      hold(1'b1, 3);
      settle();
      chk("reset_level", int'(btn_level), 0);

      // Clean press held 20 cycles, then clean release.
      clear_obs();
      e0 = edge_n + 1;
      hold(1'b0, 20);
      settle();
      chk("clean_press_count", press_edges.size(), 1);
      chk("clean_press_edge", (press_edges.size() > 0) ? press_edges[0] - e0 : -1, 6);
      chk("clean_press_level", int'(btn_level), 1);
      r0 = edge_n + 1;
      hold(1'b1, 10);
      settle();
      chk("clean_release_edge", (rel_edges.size() > 0) ? rel_edges[0] - r0 : -1, 6);

      // Bounce before settling pressed.
      clear_obs();
      e0 = edge_n + 1;
      hold(1'b0, 3);
      hold(1'b1, 1);
      hold(1'b0, 12);
      settle();
      chk("bounce_press_count", press_edges.size(), 1);
      chk("bounce_press_edge", (press_edges.size() > 0) ? press_edges[0] - (e0 + 4) : -1, 6);
      hold(1'b1, 10);

      // Short glitch must be ignored.
      clear_obs();
      hold(1'b0, 3);
      hold(1'b1, 10);
      settle();
      chk("glitch_press_count", press_edges.size(), 0);
      chk("glitch_release_count", rel_edges.size(), 0);
      chk("glitch_level", int'(btn_level), 0);

      // Reset mid-debounce, then release: nothing emitted.
      clear_obs();
      hold(1'b0, 4);
      step(1'b0, 1'b1);
      hold(1'b1, 15);
      settle();
      chk("rst_mid_press_count", press_edges.size(), 0);
      chk("rst_mid_release_count", rel_edges.size(), 0);
      chk("rst_mid_level", int'(btn_level), 0);

      // Reset while still held: re-debounced into one press.
      clear_obs();
      hold(1'b0, 3);
      step(1'b0, 1'b1);
      hold(1'b0, 12);
      settle();
      chk("rst_held_press_count", press_edges.size(), 1);
      hold(1'b1, 10);

      // Long hold then release.
      clear_obs();
      e0 = edge_n + 1;
      hold(1'b0, 30);
      r0 = edge_n + 1;
      hold(1'b1, 12);
      settle();
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      chk("long_count", long_edges.size(), 1);
      chk("long_edge", (long_edges.size() > 0) ? long_edges[0] - e0 : -1, 16);
`else
      chk("long_count", long_edges.size(), 0);
`endif
      chk("long_release_count", rel_edges.size(), 1);
      chk("long_release_edge", (rel_edges.size() > 0) ? rel_edges[0] - r0 : -1, 6);
      chk("long_release_level", int'(btn_level), 0);

      // Randomized bouncing with occasional long holds and resets.
      for (int i = 0; i < 400; i++) begin
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 6);
         b   = 1'($urandom_range(0, 1));
         for (int j = 0; j < len; j++) begin
            step(b, (j == 0) && ($urandom_range(0, 40) == 0));
         end
      end
      settle();
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
